// File: rtl/rv_m_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 encodings,
// FSM state type and the default operand width.
package rv_m_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } md_state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core and the multiply/divide unit.
// The core (master) issues operands and a destination index; the unit (slave)
// answers with a register-file-shaped write request.
interface muldiv_unit_if #(
  parameter int XLEN = rv_m_pkg::XLEN_DEFAULT
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd;
  logic            busy;
  logic            done;
  logic            we;
  logic [4:0]      waddr;
  logic [XLEN-1:0] wdata;

  modport master (
    output start, funct3, rs1_data, rs2_data, rd,
    input  busy, done, we, waddr, wdata
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data, rd,
    output busy, done, we, waddr, wdata
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. One XLEN-step shift datapath serves
// both shift-add multiplication (LSB first) and restoring division (MSB first),
// sharing a 2*XLEN accumulator and an XLEN+1-bit adder/subtractor.
// Divide-by-zero and signed overflow skip the iteration and go straight to DONE.
module muldiv_unit
  import rv_m_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_unit_if.slave  bus
);

  localparam int CW = 6;

  md_state_t         state_q, state_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [4:0]        rd_q, rd_d;
  logic              sign_q, sign_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              we_q, we_d;
  logic [4:0]        waddr_q, waddr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              add_sub;
  logic [XLEN:0]     add_a, add_b, add_sum;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, result;

  // Decode incoming operands: signedness, magnitudes and special cases.
  always_comb begin
    a_signed = !(bus.funct3 == F3_MULHU || bus.funct3 == F3_DIVU || bus.funct3 == F3_REMU);
    b_signed = (bus.funct3 == F3_MUL) || (bus.funct3 == F3_MULH) ||
               (bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM);
    a_neg    = a_signed && bus.rs1_data[XLEN-1];
    b_neg    = b_signed && bus.rs2_data[XLEN-1];
    a_mag    = a_neg ? -bus.rs1_data : bus.rs1_data;
    b_mag    = b_neg ? -bus.rs2_data : bus.rs2_data;
    div_zero = bus.funct3[2] && (bus.rs2_data == '0);
    div_ovf  = bus.funct3[2] && !bus.funct3[0] &&
               (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_data == '1);
  end

  // Shared adder: accumulate for multiply, trial-subtract the divisor for divide.
  always_comb begin
    add_sub = funct3_q[2];
    if (add_sub) begin
      add_a = acc_q[2*XLEN-1:XLEN-1];
      add_b = {1'b0, b_q};
    end else begin
      add_a = {1'b0, acc_q[2*XLEN-1:XLEN]};
      add_b = acc_q[0] ? {1'b0, b_q} : '0;
    end
    add_sum = add_a + (add_b ^ {(XLEN+1){add_sub}}) + {{XLEN{1'b0}}, add_sub};
  end

  // Sign fix-up and result selection applied in the DONE state.
  always_comb begin
    prod = sign_q ? -acc_q : acc_q;
    quo  = sign_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = sign_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (funct3_q)
      F3_MUL:                     result = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:            result = quo;
      default:                    result = rem;
    endcase
  end

  // Next-state logic: accept, iterate one bit per cycle, then publish the write.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    b_d      = b_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    sign_d   = sign_q;
    cnt_d    = cnt_q;
    busy_d   = done_q ? 1'b0 : busy_q;
    done_d   = 1'b0;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !busy_q) begin
          funct3_d = bus.funct3;
          rd_d     = bus.rd;
          cnt_d    = '0;
          busy_d   = 1'b1;
          if (div_zero) begin
            acc_d   = {bus.rs1_data, {XLEN{1'b1}}};
            b_d     = '0;
            sign_d  = 1'b0;
            state_d = DONE;
          end else if (div_ovf) begin
            acc_d   = {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
            b_d     = '0;
            sign_d  = 1'b0;
            state_d = DONE;
          end else if (bus.funct3[2]) begin
            acc_d   = {{XLEN{1'b0}}, a_mag};
            b_d     = b_mag;
            sign_d  = bus.funct3[1] ? a_neg : (a_neg ^ b_neg);
            state_d = CALC;
          end else begin
            acc_d   = {{XLEN{1'b0}}, b_mag};
            b_d     = a_mag;
            sign_d  = a_neg ^ b_neg;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (funct3_q[2]) begin
          if (!add_sum[XLEN]) acc_d = {add_sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          else                acc_d = {acc_q[2*XLEN-2:0], 1'b0};
        end else begin
          acc_d = {add_sum, acc_q[XLEN-1:1]};
        end
        if (cnt_q == CW'(XLEN-1)) state_d = DONE;
        else                      cnt_d   = cnt_q + CW'(1);
      end
      DONE: begin
        done_d  = 1'b1;
        we_d    = (rd_q != 5'd0);
        waddr_d = rd_q;
        wdata_d = result;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      b_q      <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      sign_q   <= sign_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.we    = we_q;
  assign bus.waddr = waddr_q;
  assign bus.wdata = wdata_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed RV32M results, latency,
// start-while-busy handling, reset mid-calculation and rd=0 write suppression.
module tb_muldiv_unit;
  import rv_m_pkg::*;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one request at the falling edge and hold start for a single rising edge.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    bus.funct3   = f3;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.rd       = rd;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
  endtask

  // Count cycles from acceptance until done is seen, bounded.
  task automatic waitDone(output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic runOp(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp_data, input int exp_lat);
    int lat;
    applyStimulus(f3, a, b, rd);
    checkOutput({tag, " busy"}, 32'(bus.busy), 32'd1);
    waitDone(lat);
    checkOutput({tag, " latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, " we"}, 32'(bus.we), (rd != 5'd0) ? 32'd1 : 32'd0);
    checkOutput({tag, " waddr"}, 32'(bus.waddr), 32'(rd));
    checkOutput({tag, " wdata"}, bus.wdata, exp_data);
    @(posedge clk);
    #1;
    checkOutput({tag, " done pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int lat;
    int done_count;
    int first_lat;
    logic [31:0] got_data;
    logic [4:0]  got_addr;
    logic saw_we;

    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.funct3   = '0;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.rd       = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy",  32'(bus.busy),  32'd0);
    checkOutput("reset done",  32'(bus.done),  32'd0);
    checkOutput("reset we",    32'(bus.we),    32'd0);
    checkOutput("reset waddr", 32'(bus.waddr), 32'd0);
    checkOutput("reset wdata", bus.wdata,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Multiply family.
    runOp("mul 7x6",       F3_MUL,    32'd7,        32'd6,        5'd5,  32'h0000002A, 33);
    runOp("mul -1x-1",     F3_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'h00000001, 33);
    runOp("mulh -1x-1",    F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000, 33);
    runOp("mulhu max",     F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFE, 33);
    runOp("mulhsu -1x2",   F3_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd9,  32'hFFFFFFFF, 33);

    // Divide family, back-to-back on the cycle after each done.
    runOp("div -7/2",      F3_DIV,    32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, 33);
    runOp("rem -7/2",      F3_REM,    32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, 33);
    runOp("div 7/-2",      F3_DIV,    32'd7,        32'hFFFFFFFE, 5'd12, 32'hFFFFFFFD, 33);
    runOp("rem 7/-2",      F3_REM,    32'd7,        32'hFFFFFFFE, 5'd13, 32'h00000001, 33);
    runOp("divu 100/7",    F3_DIVU,   32'd100,      32'd7,        5'd14, 32'd14,       33);
    runOp("remu 100/7",    F3_REMU,   32'd100,      32'd7,        5'd15, 32'd2,        33);

    // Special cases complete one cycle after accept.
    runOp("divu 5/0",      F3_DIVU,   32'd5,        32'd0,        5'd16, 32'hFFFFFFFF, 1);
    runOp("rem 5/0",       F3_REM,    32'd5,        32'd0,        5'd17, 32'd5,        1);
    runOp("div ovf",       F3_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, 1);
    runOp("rem ovf",       F3_REM,    32'h80000000, 32'hFFFFFFFF, 5'd19, 32'd0,        1);

    // A second start during CALC is ignored.
    applyStimulus(F3_MUL, 32'd7, 32'd6, 5'd3);
    done_count = 0;
    first_lat  = 0;
    got_data   = '0;
    got_addr   = '0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk);
      #1;
      if (c == 10) begin
        bus.funct3   = F3_DIVU;
        bus.rs1_data = 32'd100;
        bus.rs2_data = 32'd7;
        bus.rd       = 5'd9;
        bus.start    = 1'b1;
      end else begin
        bus.start    = 1'b0;
      end
      if (bus.done === 1'b1) begin
        done_count++;
        got_data  = bus.wdata;
        got_addr  = bus.waddr;
        first_lat = c;
      end
    end
    checkOutput("ignore done count", 32'(done_count), 32'd1);
    checkOutput("ignore latency",    32'(first_lat),  32'd33);
    checkOutput("ignore wdata",      got_data,        32'h0000002A);
    checkOutput("ignore waddr",      32'(got_addr),   32'd3);

    // A start held in the done cycle is not accepted.
    applyStimulus(F3_DIVU, 32'd100, 32'd7, 5'd4);
    waitDone(lat);
    checkOutput("done-cycle first wdata", bus.wdata, 32'd14);
    bus.funct3   = F3_MUL;
    bus.rs1_data = 32'd7;
    bus.rs2_data = 32'd6;
    bus.rd       = 5'd6;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    checkOutput("done-cycle start busy", 32'(bus.busy), 32'd0);
    done_count = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) done_count++;
    end
    checkOutput("done-cycle start ignored", 32'(done_count), 32'd0);
    checkOutput("done-cycle waddr held",    32'(bus.waddr),  32'd4);
    checkOutput("done-cycle wdata held",    bus.wdata,       32'd14);

    // Reset in the middle of CALC abandons the operation.
    applyStimulus(F3_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7);
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midreset busy",  32'(bus.busy),  32'd0);
    checkOutput("midreset done",  32'(bus.done),  32'd0);
    checkOutput("midreset we",    32'(bus.we),    32'd0);
    checkOutput("midreset waddr", 32'(bus.waddr), 32'd0);
    checkOutput("midreset wdata", bus.wdata,      32'd0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    saw_we = 1'b0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk);
      #1;
      if (bus.we === 1'b1) saw_we = 1'b1;
    end
    checkOutput("midreset no write", 32'(saw_we), 32'd0);
    runOp("after reset mul", F3_MUL, 32'd7, 32'd6, 5'd5, 32'h0000002A, 33);

    // rd=0 computes and pulses done without a write.
    runOp("mul rd0", F3_MUL, 32'd3, 32'd5, 5'd0, 32'd15, 33);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
